// File: rtl/apb_pkg.sv
// Shared types for the APB slave demux.
//   apb_rule_t         : address rule {base, mask}; a hit is (addr & mask) == base
//   apb_demux_state_e  : demux FSM states
//   DefaultSlvRules    : four 4 KiB windows at 0x0000_0000, 0x1000_0000, 0x2000_0000, 0x3000_0000
//   rule_hit()         : single-rule match helper used by the decoder
package apb_pkg;

  // Rules are stored at a fixed width so one parameter type serves any address width up to 64.
  localparam int unsigned RuleAw = 64;
  localparam int unsigned MaxSlv = 16;

  typedef struct packed {
    logic [RuleAw-1:0] base;
    logic [RuleAw-1:0] mask;
  } apb_rule_t;

  typedef enum logic [1:0] {
    StIdle,
    StDSetup,
    StDAccess,
    StResp
  } apb_demux_state_e;

  // base = all ones with mask = 0 can never match: used for unused slots.
  localparam apb_rule_t NoRule = '{base: '1, mask: '0};

  localparam apb_rule_t [MaxSlv-1:0] DefaultSlvRules = '{
    0:       '{base: 64'h0000_0000_0000_0000, mask: 64'h0000_0000_FFFF_F000},
    1:       '{base: 64'h0000_0000_1000_0000, mask: 64'h0000_0000_FFFF_F000},
    2:       '{base: 64'h0000_0000_2000_0000, mask: 64'h0000_0000_FFFF_F000},
    3:       '{base: 64'h0000_0000_3000_0000, mask: 64'h0000_0000_FFFF_F000},
    default: NoRule
  };

  function automatic logic rule_hit(input logic [RuleAw-1:0] addr, input apb_rule_t rule);
    return (addr & rule.mask) == rule.base;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational priority address decoder.
//   addr_i : transfer address
//   hit_o  : some rule matched
//   idx_o  : index of the matching rule; lowest index wins when several match
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter apb_rule_t [MaxSlv-1:0] SLV_RULES = DefaultSlvRules,
  localparam int unsigned IdxW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  output logic                      hit_o,
  output logic [IdxW-1:0]           idx_o
);

  logic [RuleAw-1:0] addr_ext;

  assign addr_ext = RuleAw'(addr_i);

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = int'(NUM_SLV) - 1; i >= 0; i--) begin
      if (rule_hit(addr_ext, SLV_RULES[i])) begin
        hit_o = 1'b1;
        idx_o = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/apb_slv_demux.sv
// APB fan-out: one upstream requester routed to NUM_SLV downstream slaves by address.
// The downstream side is fully registered, unmapped addresses answer with pslverr, and a
// watchdog aborts slaves that stay in ACCESS too long.
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   psel_i .. pwdata_i      : upstream request
//   prdata_o/pready_o/pslverr_o : upstream response (pready_o is a one-cycle pulse)
//   psel_o (one-hot), penable_o, pwrite_o, paddr_o, pwdata_o : downstream request
//   prdata_i/pready_i/pslverr_i : per-slave responses, slave k data at [k*W +: W]
//   timeout_o               : one-cycle pulse on watchdog abort
//   timeout_addr_o          : address of the last aborted transfer
module apb_slv_demux
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter apb_rule_t [MaxSlv-1:0] SLV_RULES = DefaultSlvRules
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              psel_i,
  input  logic                              penable_i,
  input  logic                              pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0]         paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]         pwdata_i,
  output logic [APB_DATA_WIDTH-1:0]         prdata_o,
  output logic                              pready_o,
  output logic                              pslverr_o,
  output logic [NUM_SLV-1:0]                psel_o,
  output logic                              penable_o,
  output logic                              pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]         paddr_o,
  output logic [APB_DATA_WIDTH-1:0]         pwdata_o,
  input  logic [NUM_SLV*APB_DATA_WIDTH-1:0] prdata_i,
  input  logic [NUM_SLV-1:0]                pready_i,
  input  logic [NUM_SLV-1:0]                pslverr_i,
  output logic                              timeout_o,
  output logic [APB_ADDR_WIDTH-1:0]         timeout_addr_o
);

  localparam int unsigned IdxW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  apb_demux_state_e state_q, state_d;

  logic [NUM_SLV-1:0]        psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [APB_DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                      pready_q, pready_d;
  logic                      pslverr_q, pslverr_d;
  logic                      timeout_q, timeout_d;
  logic [APB_ADDR_WIDTH-1:0] timeout_addr_q, timeout_addr_d;

  logic                      dec_hit;
  logic [IdxW-1:0]           dec_idx;
  logic [NUM_SLV-1:0]        dec_onehot;
  logic                      cnt_clr, cnt_inc, wdog_expire;

  logic [APB_DATA_WIDTH-1:0] slv_rdata [NUM_SLV];

  for (genvar k = 0; k < NUM_SLV; k++) begin : g_rdata
    assign slv_rdata[k] = prdata_i[k*APB_DATA_WIDTH +: APB_DATA_WIDTH];
  end

  apb_addr_decode #(
    .NUM_SLV        (NUM_SLV),
    .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
    .SLV_RULES      (SLV_RULES)
  ) u_decode (
    .addr_i (paddr_i),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  always_comb begin
    dec_onehot = '0;
    for (int k = 0; k < int'(NUM_SLV); k++) begin
      dec_onehot[k] = (dec_idx == IdxW'(k));
    end
  end

  // Watchdog: counts ACCESS cycles without pready; expires on the last allowed cycle.
  if (TIMEOUT_CYCLES > 0) begin : g_wdog
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
        cnt_d = '0;
      end else if (cnt_inc) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign wdog_expire = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_wdog
    logic unused_cnt_ctrl;
    assign unused_cnt_ctrl = cnt_clr ^ cnt_inc;
    assign wdog_expire     = 1'b0;
  end

  always_comb begin
    state_d        = state_q;
    psel_d         = psel_q;
    penable_d      = penable_q;
    pwrite_d       = pwrite_q;
    paddr_d        = paddr_q;
    pwdata_d       = pwdata_q;
    idx_d          = idx_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = rsp_err_q;
    pready_d       = 1'b0;
    prdata_d       = '0;
    pslverr_d      = 1'b0;
    timeout_d      = 1'b0;
    timeout_addr_d = timeout_addr_q;
    cnt_clr        = 1'b0;
    cnt_inc        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (psel_i) begin
          paddr_d  = paddr_i;
          pwdata_d = pwdata_i;
          pwrite_d = pwrite_i;
          idx_d    = dec_idx;
          if (dec_hit) begin
            psel_d    = dec_onehot;
            penable_d = 1'b0;
            state_d   = StDSetup;
          end else begin
            // Unmapped: answer locally, the downstream bus never sees it.
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            state_d     = StResp;
          end
        end
      end

      StDSetup: begin
        if (!psel_i) begin
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = StIdle;
        end else begin
          penable_d = 1'b1;
          cnt_clr   = 1'b1;
          state_d   = StDAccess;
        end
      end

      StDAccess: begin
        if (!psel_i) begin
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = StIdle;
        end else if (pready_i[idx_q]) begin
          // Ready on the expiry cycle still counts as a normal completion.
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : slv_rdata[idx_q];
          rsp_err_d   = pslverr_i[idx_q];
          state_d     = StResp;
        end else if (wdog_expire) begin
          psel_d         = '0;
          penable_d      = 1'b0;
          rsp_rdata_d    = '0;
          rsp_err_d      = 1'b1;
          timeout_d      = 1'b1;
          timeout_addr_d = paddr_q;
          state_d        = StResp;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      StResp: begin
        // Stay here through the pready cycle so the still-high psel_i of the finishing
        // transfer is not mistaken for a new request.
        if (pready_q) begin
          state_d = StIdle;
        end else if (!psel_i) begin
          state_d = StIdle;
        end else if (penable_i) begin
          pready_d  = 1'b1;
          prdata_d  = rsp_rdata_q;
          pslverr_d = rsp_err_q;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      psel_q         <= '0;
      penable_q      <= 1'b0;
      pwrite_q       <= 1'b0;
      paddr_q        <= '0;
      pwdata_q       <= '0;
      idx_q          <= '0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      prdata_q       <= '0;
      pready_q       <= 1'b0;
      pslverr_q      <= 1'b0;
      timeout_q      <= 1'b0;
      timeout_addr_q <= '0;
    end else begin
      state_q        <= state_d;
      psel_q         <= psel_d;
      penable_q      <= penable_d;
      pwrite_q       <= pwrite_d;
      paddr_q        <= paddr_d;
      pwdata_q       <= pwdata_d;
      idx_q          <= idx_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
      prdata_q       <= prdata_d;
      pready_q       <= pready_d;
      pslverr_q      <= pslverr_d;
      timeout_q      <= timeout_d;
      timeout_addr_q <= timeout_addr_d;
    end
  end

  assign psel_o         = psel_q;
  assign penable_o      = penable_q;
  assign pwrite_o       = pwrite_q;
  assign paddr_o        = paddr_q;
  assign pwdata_o       = pwdata_q;
  assign prdata_o       = prdata_q;
  assign pready_o       = pready_q;
  assign pslverr_o      = pslverr_q;
  assign timeout_o      = timeout_q;
  assign timeout_addr_o = timeout_addr_q;

endmodule
